// File: rtl/traffic_ctrl_param_pkg.sv
// Shared types for the two-road lamp controller.
// TRAFFIC_FLASH_MODE_EN enables the FLASH state in the users of this package.
package traffic_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;
  localparam logic [2:0] OFF    = 3'b000;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  typedef enum logic [2:0] {
    AR_EW = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_NS = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    PED   = 3'd6,
    FLASH = 3'd7
  } state_e;

  function automatic logic [2:0] ns_lamp(state_e s);
    case (s)
      NS_G:    ns_lamp = GREEN;
      NS_Y:    ns_lamp = YELLOW;
      default: ns_lamp = RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(state_e s);
    case (s)
      EW_G:    ew_lamp = GREEN;
      EW_Y:    ew_lamp = YELLOW;
      default: ew_lamp = RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_ctrl_param_if.sv
// Pedestrian handshake and lamp bundle of the controller.
// TRAFFIC_FLASH_MODE_EN adds the flash request line.
interface traffic_ctrl_param_if;

  logic       ped_req;
  logic       ped_ack;
  logic [2:0] light_ns;
  logic [2:0] light_ew;
  logic       walk;
  logic       tick;
`ifdef TRAFFIC_FLASH_MODE_EN
  logic       flash;

  modport master (
    output ped_req,
    output flash,
    input  ped_ack,
    input  light_ns,
    input  light_ew,
    input  walk,
    input  tick
  );

  modport slave (
    input  ped_req,
    input  flash,
    output ped_ack,
    output light_ns,
    output light_ew,
    output walk,
    output tick
  );
`else
  modport master (
    output ped_req,
    input  ped_ack,
    input  light_ns,
    input  light_ew,
    input  walk,
    input  tick
  );

  modport slave (
    input  ped_req,
    output ped_ack,
    output light_ns,
    output light_ew,
    output walk,
    output tick
  );
`endif

endinterface

// File: rtl/traffic_ctrl_param_tick_prescaler.sv
// Divides fast_clk into a one-cycle tick every TICK_DIV cycles.
// restart zeroes the count so a new phase starts on a tick boundary.
module tick_prescaler #(
  parameter int TICK_DIV = 25000000
) (
  input  logic fast_clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_ctrl_param.sv
// Two-road lamp controller with all-red clearance and pedestrian phase.
// TRAFFIC_FLASH_MODE_EN adds a flashing-yellow override state.
module traffic_ctrl_param #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int PED_T    = 5
) (
  input  logic                 fast_clk,
  input  logic                 reset,
  traffic_ctrl_param_if.slave  bus
);

  import traffic_pkg::*;

  localparam int MAXD = (1 << CNT_W) - 1;

  if (TICK_DIV < 2 ||
      GREEN_T < 1 || GREEN_T > MAXD ||
      YELLOW_T < 1 || YELLOW_T > MAXD ||
      ALLRED_T < 1 || ALLRED_T > MAXD ||
      PED_T < 1 || PED_T > MAXD) begin : g_param_err
    $error("traffic_ctrl_param: illegal parameter");
  end

  function automatic logic [CNT_W-1:0] dur(state_e s);
    case (s)
      NS_G, EW_G: dur = CNT_W'(GREEN_T);
      NS_Y, EW_Y: dur = CNT_W'(YELLOW_T);
      PED:        dur = CNT_W'(PED_T);
      default:    dur = CNT_W'(ALLRED_T);
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             dir_q, dir_d;
  logic [2:0]       lns_q, lns_d;
  logic [2:0]       lew_q, lew_d;
  logic             walk_q, walk_d;
  logic             tick;
  logic             entry;
  logic             expire;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .fast_clk (fast_clk),
    .reset    (reset),
    .restart  (entry),
    .tick     (tick)
  );

  assign expire = tick && (cnt_q == CNT_W'(1));
  assign entry  = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      NS_G:  if (expire) state_d = NS_Y;
      NS_Y:  if (expire) state_d = AR_NS;
      AR_NS: if (expire) begin
        if (pend_q) begin
          state_d = PED;
          dir_d   = DIR_EW;
        end else begin
          state_d = EW_G;
        end
      end
      EW_G:  if (expire) state_d = EW_Y;
      EW_Y:  if (expire) state_d = AR_EW;
      AR_EW: if (expire) begin
        if (pend_q) begin
          state_d = PED;
          dir_d   = DIR_NS;
        end else begin
          state_d = NS_G;
        end
      end
      PED:   if (expire) state_d = (dir_q == DIR_EW) ? EW_G : NS_G;
`ifdef TRAFFIC_FLASH_MODE_EN
      FLASH: state_d = AR_EW;
`endif
      default: state_d = AR_EW;
    endcase
`ifdef TRAFFIC_FLASH_MODE_EN
    if (bus.flash) begin
      state_d = FLASH;
    end
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (entry) begin
      cnt_d = dur(state_d);
    end else if (tick) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // A request made in the PED entry cycle is still covered by the old latch.
  always_comb begin
    pend_d = pend_q;
    ack_d  = 1'b0;
    if (bus.ped_req && !pend_q) begin
      pend_d = 1'b1;
      ack_d  = 1'b1;
    end
    if (entry && state_d == PED) begin
      pend_d = 1'b0;
    end
  end

  always_comb begin
    lns_d  = ns_lamp(state_d);
    lew_d  = ew_lamp(state_d);
    walk_d = (state_d == PED);
`ifdef TRAFFIC_FLASH_MODE_EN
    if (state_d == FLASH) begin
      if (state_q != FLASH) begin
        lns_d = YELLOW;
        lew_d = YELLOW;
      end else if (tick) begin
        lns_d = (lns_q == YELLOW) ? OFF : YELLOW;
        lew_d = (lew_q == YELLOW) ? OFF : YELLOW;
      end else begin
        lns_d = lns_q;
        lew_d = lew_q;
      end
    end
`endif
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      state_q <= AR_EW;
      cnt_q   <= CNT_W'(ALLRED_T);
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      dir_q   <= DIR_NS;
      lns_q   <= RED;
      lew_q   <= RED;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      dir_q   <= dir_d;
      lns_q   <= lns_d;
      lew_q   <= lew_d;
      walk_q  <= walk_d;
    end
  end

  assign bus.ped_ack  = ack_q;
  assign bus.light_ns = lns_q;
  assign bus.light_ew = lew_q;
  assign bus.walk     = walk_q;
  assign bus.tick     = tick;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Randomized scoreboard bench for traffic_ctrl_param.
// Build with TRAFFIC_FLASH_MODE_EN to also exercise the flash override.
module tb_traffic_ctrl_param;

  localparam int TD = 4;
  localparam int GT = 3;
  localparam int YT = 2;
  localparam int AT = 1;
  localparam int PT = 2;

  localparam logic [2:0] C_RED = 3'b100;
  localparam logic [2:0] C_GRN = 3'b010;
  localparam logic [2:0] C_YEL = 3'b001;
  localparam logic [2:0] C_OFF = 3'b000;

  localparam int P_NSG  = 0;
  localparam int P_NSY  = 1;
  localparam int P_ARNS = 2;
  localparam int P_EWG  = 3;
  localparam int P_EWY  = 4;
  localparam int P_AREW = 5;
  localparam int P_PED  = 6;
  localparam int P_FL   = 7;

`ifdef TRAFFIC_FLASH_MODE_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic       tick;
    logic       ack;
  } exp_t;

  logic clk;
  logic reset;
  traffic_ctrl_param_if bus();

  traffic_ctrl_param #(
    .TICK_DIV (TD),
    .CNT_W    (8),
    .GREEN_T  (GT),
    .YELLOW_T (YT),
    .ALLRED_T (AT),
    .PED_T    (PT)
  ) dut (
    .fast_clk (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t q[$];

  int m_ph   = P_AREW;
  int m_age  = 0;
  int m_ret  = P_NSG;
  bit m_pend = 1'b0;
  bit m_ack  = 1'b0;
  bit m_fy   = 1'b0;

  function automatic int dur_cycles(int ph);
    case (ph)
      P_NSG, P_EWG: return GT * TD;
      P_NSY, P_EWY: return YT * TD;
      P_PED:        return PT * TD;
      default:      return AT * TD;
    endcase
  endfunction

  function automatic int succ(int ph);
    case (ph)
      P_NSG:   return P_NSY;
      P_NSY:   return P_ARNS;
      P_ARNS:  return m_pend ? P_PED : P_EWG;
      P_EWG:   return P_EWY;
      P_EWY:   return P_AREW;
      P_AREW:  return m_pend ? P_PED : P_NSG;
      P_PED:   return m_ret;
      default: return P_AREW;
    endcase
  endfunction

  task automatic model_step(input bit req, input bit fl, input bit rs);
    int nxt;
    bit tk;
    if (rs) begin
      m_ph   = P_AREW;
      m_age  = 0;
      m_ret  = P_NSG;
      m_pend = 1'b0;
      m_ack  = 1'b0;
      m_fy   = 1'b0;
      return;
    end
    tk  = (m_age % TD) == TD - 1;
    nxt = m_ph;
    if (m_ph != P_FL && m_age == dur_cycles(m_ph) - 1) nxt = succ(m_ph);
    if (FLASH_EN && fl) nxt = P_FL;
    else if (m_ph == P_FL) nxt = P_AREW;
    m_ack = req && !m_pend;
    if (req && !m_pend) m_pend = 1'b1;
    if (nxt != m_ph && nxt == P_PED) begin
      m_pend = 1'b0;
      m_ret  = (m_ph == P_ARNS) ? P_EWG : P_NSG;
    end
    if (nxt == P_FL) m_fy = (m_ph != P_FL) ? 1'b1 : (tk ? !m_fy : m_fy);
    m_age = (nxt != m_ph) ? 0 : m_age + 1;
    m_ph  = nxt;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.ns   = C_RED;
    e.ew   = C_RED;
    e.walk = (m_ph == P_PED);
    e.tick = (m_age % TD) == TD - 1;
    e.ack  = m_ack;
    case (m_ph)
      P_NSG: e.ns = C_GRN;
      P_NSY: e.ns = C_YEL;
      P_EWG: e.ew = C_GRN;
      P_EWY: e.ew = C_YEL;
      P_FL: begin
        e.ns = m_fy ? C_YEL : C_OFF;
        e.ew = m_fy ? C_YEL : C_OFF;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic drive(input bit req, input bit fl, input bit rs);
    bus.ped_req = req;
`ifdef TRAFFIC_FLASH_MODE_EN
    bus.flash = fl;
`endif
    reset = rs;
    @(posedge clk);
    model_step(req, fl, rs);
    q.push_back(model_out());
    cyc++;
    #1;
  endtask

  task automatic wait_until(input int ph, input int age);
    int n;
    n = 0;
    while (!(m_ph == ph && m_age == age) && n < 300) begin
      drive(1'b0, 1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("light_ns", bus.light_ns, e.ns);
        chk("light_ew", bus.light_ew, e.ew);
        chk("walk", {2'b00, bus.walk}, {2'b00, e.walk});
        chk("tick", {2'b00, bus.tick}, {2'b00, e.tick});
        chk("ped_ack", {2'b00, bus.ped_ack}, {2'b00, e.ack});
        ok = 1'b1;
        if (bus.walk && (bus.light_ns != C_RED || bus.light_ew != C_RED)) ok = 1'b0;
        if (bus.light_ns == C_GRN && bus.light_ew != C_RED) ok = 1'b0;
        if (bus.light_ew == C_GRN && bus.light_ns != C_RED) ok = 1'b0;
        chk("safety", {2'b00, ok}, 3'b001);
      end
    end
  end

  initial begin : stim
    bit fl;
    bus.ped_req = 1'b0;
`ifdef TRAFFIC_FLASH_MODE_EN
    bus.flash = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    repeat (100) drive(1'b0, 1'b0, 1'b0);

    wait_until(P_NSG, 2);
    drive(1'b1, 1'b0, 1'b0);
    repeat (80) drive(1'b0, 1'b0, 1'b0);

    repeat (30) drive(1'b1, 1'b0, 1'b0);
    repeat (60) drive(1'b0, 1'b0, 1'b0);

    wait_until(P_AREW, AT * TD - 1);
    drive(1'b1, 1'b0, 1'b0);
    repeat (100) drive(1'b0, 1'b0, 1'b0);

    wait_until(P_EWY, 3);
    drive(1'b0, 1'b0, 1'b1);
    repeat (60) drive(1'b0, 1'b0, 1'b0);

    if (FLASH_EN) begin
      drive(1'b1, 1'b0, 1'b0);
      wait_until(P_PED, 1);
      repeat (6) drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      repeat (14) drive(1'b0, 1'b1, 1'b0);
      repeat (40) drive(1'b0, 1'b0, 1'b0);
    end

    fl = 1'b0;
    repeat (2500) begin
      if (FLASH_EN && $urandom_range(0, 79) == 0) fl = !fl;
      drive($urandom_range(0, 9) == 0, fl, $urandom_range(0, 399) == 0);
    end
    repeat (20) drive(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
